// File: rtl/fm_radio_pkg.sv
// Shared FM radio definitions: quantisation scale, dequantise helper and the
// interpolator FSM state type.
package fm_radio_pkg;

    localparam int QUANT_BITS = 10;
    localparam int DEQ_W      = 64;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2
    } fir_state_t;

    // Arithmetic shift that rounds toward zero instead of toward minus infinity.
    function automatic logic signed [DEQ_W-1:0] DEQUANTIZE(input logic signed [DEQ_W-1:0] v);
        if (v < 0)
            return -((-v) >>> QUANT_BITS);
        return v >>> QUANT_BITS;
    endfunction

endpackage

// File: rtl/fir_interp_mac.sv
// Combinational multiply-accumulate step: truncate product, dequantise, add.
module fir_interp_mac
    import fm_radio_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic signed [DATA_SIZE-1:0] coeff,
    input  logic signed [DATA_SIZE-1:0] x,
    input  logic signed [DATA_SIZE-1:0] acc_in,
    output logic signed [DATA_SIZE-1:0] acc_out
);

    // A DATA_SIZE-wide multiply keeps exactly the low DATA_SIZE product bits.
    logic signed [DATA_SIZE-1:0] prod_trunc;

    assign prod_trunc = coeff * x;
    assign acc_out    = acc_in + DATA_SIZE'(DEQUANTIZE(DEQ_W'(prod_trunc)));

endmodule

// File: rtl/fir_interp.sv
// Polyphase FIR interpolator: one FIFO sample in, INTERP filtered samples out.
// Define FIR_INTERP_GAIN_EN to scale outputs by INTERP (zero-stuffing gain).
module fir_interp
    import fm_radio_pkg::*;
#(
    parameter int TAPS      = 32,
    parameter int INTERP    = 4,
    parameter int DATA_SIZE = 32,
    parameter logic signed [DATA_SIZE-1:0] GLOBAL_COEFF [0:TAPS-1] = '{
        -3, -6, -12, -19, -27, -33, -30, -13,
        21, 78, 155, 249, 349, 446, 526, 579,
        579, 526, 446, 349, 249, 155, 78, 21,
        -13, -30, -33, -27, -19, -12, -6, -3
    }
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] x_in,
    output logic                        x_rd_en,
    input  logic                        x_empty,
    output logic signed [DATA_SIZE-1:0] y_out,
    output logic                        y_wr_en,
    input  logic                        y_out_full
);

    localparam int K     = TAPS / INTERP;
    localparam int K_W   = (K > 1) ? $clog2(K) : 1;
    localparam int P_W   = $clog2(INTERP);
    localparam int IDX_W = $clog2(TAPS);

    if ((TAPS % INTERP) != 0 || INTERP < 2 || (INTERP & (INTERP - 1)) != 0) begin : g_bad_params
        $error("fir_interp: INTERP must be a power of two >= 2 dividing TAPS");
    end

    fir_state_t                  state_reg, state_next;
    logic [P_W-1:0]              phase_reg, phase_next;
    logic [K_W-1:0]              k_reg, k_next;
    logic signed [DATA_SIZE-1:0] acc_reg, acc_next;
    logic signed [DATA_SIZE-1:0] y_out_reg, y_out_next;
    logic                        y_wr_en_reg, y_wr_en_next;
    logic signed [DATA_SIZE-1:0] x_hist      [0:K-1];
    logic signed [DATA_SIZE-1:0] x_hist_next [0:K-1];
    logic                        shift_en;

    logic [IDX_W-1:0]            coeff_idx;
    logic signed [DATA_SIZE-1:0] coeff_sel;
    logic signed [DATA_SIZE-1:0] x_sel;
    logic signed [DATA_SIZE-1:0] mac_acc;
    logic signed [DATA_SIZE-1:0] y_scaled;

    // Polyphase ordering: phase selects the sub-filter, k walks its taps.
    assign coeff_idx = (IDX_W'(k_reg) << P_W) | IDX_W'(phase_reg);
    assign coeff_sel = GLOBAL_COEFF[coeff_idx];
    assign x_sel     = x_hist[k_reg];

    fir_interp_mac #(
        .DATA_SIZE(DATA_SIZE)
    ) u_mac (
        .coeff  (coeff_sel),
        .x      (x_sel),
        .acc_in (acc_reg),
        .acc_out(mac_acc)
    );

`ifdef FIR_INTERP_GAIN_EN
    assign y_scaled = acc_reg <<< P_W;
`else
    assign y_scaled = acc_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign x_hist_next[gi] = shift_en ? x_in : x_hist[gi];
            end else begin : g_tail
                assign x_hist_next[gi] = shift_en ? x_hist[gi-1] : x_hist[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        k_next       = k_reg;
        acc_next     = acc_reg;
        y_out_next   = y_out_reg;
        y_wr_en_next = 1'b0;
        shift_en     = 1'b0;
        x_rd_en      = 1'b0;
        case (state_reg)
            READ: begin
                if (!x_empty) begin
                    x_rd_en    = 1'b1;
                    shift_en   = 1'b1;
                    phase_next = '0;
                    k_next     = '0;
                    acc_next   = '0;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_next = mac_acc;
                k_next   = k_reg + 1'b1;
                if (k_reg == K_W'(K - 1)) begin
                    k_next     = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!y_out_full) begin
                    y_wr_en_next = 1'b1;
                    y_out_next   = y_scaled;
                    if (phase_reg == P_W'(INTERP - 1)) begin
                        state_next = READ;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                        k_next     = '0;
                        acc_next   = '0;
                        state_next = COMPUTE;
                    end
                end
            end
            default: state_next = READ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= READ;
            phase_reg   <= '0;
            k_reg       <= '0;
            acc_reg     <= '0;
            y_out_reg   <= '0;
            y_wr_en_reg <= 1'b0;
            x_hist      <= '{default: '0};
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            k_reg       <= k_next;
            acc_reg     <= acc_next;
            y_out_reg   <= y_out_next;
            y_wr_en_reg <= y_wr_en_next;
            x_hist      <= x_hist_next;
        end
    end

    assign y_out   = y_out_reg;
    assign y_wr_en = y_wr_en_reg;

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: vector table plus backpressure, reset,
// starvation, latency and rounding sequences.
module tb_fir_interp;

`ifdef FIR_INTERP_GAIN_EN
    localparam int GS = 2;
`else
    localparam int GS = 0;
`endif

    localparam logic signed [31:0] C5 [0:31] = '{0: 32'sd5, default: 32'sd0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic signed [31:0] x_in = '0;
    logic               x_empty = 1'b1;
    logic               x_rd_en;
    logic signed [31:0] y_out;
    logic               y_wr_en;
    logic               y_out_full = 1'b0;

    logic signed [31:0] x_in2 = '0;
    logic               x_empty2 = 1'b1;
    logic               x_rd_en2;
    logic signed [31:0] y_out2;
    logic               y_wr_en2;
    logic               full2 = 1'b0;

    fir_interp dut (
        .clock     (clock),
        .reset     (reset),
        .x_in      (x_in),
        .x_rd_en   (x_rd_en),
        .x_empty   (x_empty),
        .y_out     (y_out),
        .y_wr_en   (y_wr_en),
        .y_out_full(y_out_full)
    );

    fir_interp #(.GLOBAL_COEFF(C5)) dut2 (
        .clock     (clock),
        .reset     (reset),
        .x_in      (x_in2),
        .x_rd_en   (x_rd_en2),
        .x_empty   (x_empty2),
        .y_out     (y_out2),
        .y_wr_en   (y_wr_en2),
        .y_out_full(full2)
    );

    int cyc = 0;
    int yq[$];
    int ycyc[$];
    int rcyc[$];
    int yq2[$];
    int nchk = 0;
    int nerr = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (y_wr_en) begin
            yq.push_back(y_out);
            ycyc.push_back(cyc);
        end
        if (x_rd_en) rcyc.push_back(cyc);
        if (y_wr_en2) yq2.push_back(y_out2);
    end

    typedef struct {
        bit rst;
        bit chk;
        int x;
        int e [4];
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input bit chk, input int x,
                       input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.rst = rst; v.chk = chk; v.x = x;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        tbl.push_back(v);
    endtask

    function automatic int g(input int v);
        return v <<< GS;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: got %0d", name, act);
        end
    endtask

    task automatic clear_q();
        yq.delete(); ycyc.delete(); rcyc.delete(); yq2.delete();
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        clear_q();
    endtask

    task automatic push(input int v);
        bit ok;
        ok = 1'b0;
        @(posedge clock); #1;
        x_in = v; x_empty = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (x_rd_en) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock); #1 x_empty = 1'b1;
        check($sformatf("pop x=%0d", v), ok, 1);
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && yq.size() < n; i++) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Impulse response reproduces the coefficient set in order.
        add(0, 1, 1024, -3, -6, -12, -19);
        add(0, 1, 0, -27, -33, -30, -13);
        add(0, 1, 0, 21, 78, 155, 249);
        add(0, 1, 0, 349, 446, 526, 579);
        add(0, 1, 0, 579, 526, 446, 349);
        add(0, 1, 0, 249, 155, 78, 21);
        add(0, 1, 0, -13, -30, -33, -27);
        add(0, 1, 0, -19, -12, -6, -3);
        // DC ramp: only once the history is full of 1024s is the output the phase sum.
        for (int i = 0; i < 7; i++) add(0, 0, 1024, 0, 0, 0, 0);
        add(0, 1, 1024, 1136, 1124, 1124, 1136);
        add(0, 1, 1024, 1136, 1124, 1124, 1136);
        // Rounding toward zero with the default first-phase coefficients.
        add(1, 1, -1024, 3, 6, 12, 19);
        add(1, 1, -1, 0, 0, 0, 0);
        add(1, 1, 300, 0, -1, -3, -5);
        add(1, 1, 1000, -2, -5, -11, -18);

        repeat (2) @(posedge clock);
        #1;
        check("reset y_out", y_out, 0);
        check("reset y_wr_en", y_wr_en, 0);
        check("reset x_rd_en", x_rd_en, 0);
        reset = 1'b0;
        clear_q();

        // Latency and throughput with a continuously non-empty FIFO.
        @(posedge clock); #1;
        x_in = 1024; x_empty = 1'b0;
        for (int i = 0; i < 200 && rcyc.size() < 2; i++) @(negedge clock);
        @(posedge clock); #1 x_empty = 1'b1;
        wait_out(8, 200);
        check("thru pop count", rcyc.size(), 2);
        check("thru out count", yq.size(), 8);
        if (rcyc.size() >= 2) check("throughput cycles", rcyc[1] - rcyc[0], 37);
        if (rcyc.size() >= 1 && ycyc.size() >= 1) check("latency cycles", ycyc[0] - rcyc[0], 10);
        if (ycyc.size() >= 2) check("phase spacing", ycyc[1] - ycyc[0], 9);
        if (yq.size() >= 1) check("latency first value", yq[0], g(-3));

        // Coefficient 5 against x = -300 rounds to -1.
        @(posedge clock); #1;
        x_in2 = -300; x_empty2 = 1'b0;
        for (int i = 0; i < 100 && !x_rd_en2; i++) @(negedge clock);
        @(posedge clock); #1 x_empty2 = 1'b1;
        for (int i = 0; i < 100 && yq2.size() < 4; i++) @(negedge clock);
        check("coef5 out count", yq2.size(), 4);
        if (yq2.size() >= 4) begin
            check("coef5 p0", yq2[0], g(-1));
            check("coef5 p1", yq2[1], 0);
        end

        // Backpressure: stall the second write well past 20 cycles.
        do_reset();
        push(1024);
        wait_out(1, 100);
        @(posedge clock); #1 y_out_full = 1'b1;
        repeat (40) @(posedge clock);
        check("stall no write", yq.size(), 1);
        #1 y_out_full = 1'b0;
        wait_out(4, 100);
        repeat (20) @(posedge clock);
        check("stall out count", yq.size(), 4);
        check("stall pop count", rcyc.size(), 1);
        if (yq.size() >= 4) begin
            check("stall p1", yq[1], g(-6));
            check("stall p2", yq[2], g(-12));
            check("stall p3", yq[3], g(-19));
        end

        // Reset mid-COMPUTE discards the pending output and clears y_out.
        yq.delete();
        push(0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("rst compute y_out", y_out, 0);
        check("rst compute y_wr_en", y_wr_en, 0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (30) @(posedge clock);
        check("rst compute no write", yq.size(), 0);

        // Starvation: empty FIFO produces no pops and no outputs.
        clear_q();
        repeat (50) @(posedge clock);
        #1;
        check("starve pops", rcyc.size(), 0);
        check("starve outputs", yq.size(), 0);
        check("starve x_rd_en", x_rd_en, 0);

        // Reset while stalled in WRITE.
        do_reset();
        push(1024);
        wait_out(1, 100);
        @(posedge clock); #1 y_out_full = 1'b1;
        repeat (15) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("rst write y_out", y_out, 0);
        check("rst write y_wr_en", y_wr_en, 0);
        @(posedge clock); #1;
        reset = 1'b0; y_out_full = 1'b0;
        repeat (30) @(posedge clock);
        check("rst write no write", yq.size(), 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            yq.delete();
            push(tbl[i].x);
            wait_out(4, 100);
            check($sformatf("row%0d count", i), yq.size(), 4);
            if (tbl[i].chk && yq.size() >= 4) begin
                for (int j = 0; j < 4; j++)
                    check($sformatf("row%0d x=%0d p%0d", i, tbl[i].x, j), yq[j], g(tbl[i].e[j]));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
